// File: rtl/rcs_serial_restore.sv
// Bit-serial minuend restore: a = diff + b + ~bin (mod 2^WIDTH), one full-adder
// slice reused LSB-first with a carry flop; valid/ready on both sides.
module rcs_fa_slice (
  input  logic x_i,
  input  logic y_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i ^ c_i;
  assign c_o = (x_i & y_i) | (y_i & c_i) | (c_i & x_i);
endmodule

module rcs_serial_restore #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] diff,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic             cout
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 bits already produced; the final bit joins at the last edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             sum_bit, carry_nxt;

  rcs_fa_slice u_fa (
    .x_i (d_sh_q[0]),
    .y_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (sum_bit),
    .c_o (carry_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_sh_q      <= d_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    d_sh_d      = d_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_sh_d     = diff;
          b_sh_d     = b;
          carry_d    = ~bin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        d_sh_d  = d_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = (res_q >> 1) | ((WIDTH-1)'(sum_bit) << (WIDTH-2));
        carry_d = carry_nxt;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          a_d         = {sum_bit, res_q};
          cout_d      = carry_nxt;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign cout      = cout_q;
endmodule
